video_filter: RTL and testbench



---
 rtl/video_pkg.sv | 15 +
 rtl/filter_channel.sv | 94 +++++++++
 rtl/video_filter.sv | 137 +++++++++++++
 tb/tb_video_filter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared video definitions for the effect chain: count widths, pixel type, control width.
package video_pkg;

    localparam int unsigned H_COUNT_W            = 11;
    localparam int unsigned V_COUNT_W            = 10;
    localparam int unsigned KNOB_W               = 10;
    localparam int unsigned VIDEO_FILTER_LATENCY = 4;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

endpackage

// File: rtl/filter_channel.sv
// One 8-bit colour channel: per-line first-order IIR low-pass (stage 2),
// high-pass emphasis (stage 3) and clamp/blank (stage 4).
module filter_channel
    import video_pkg::*;
#(
    parameter int unsigned FRAC_BITS = 10
) (
    input  logic              clk_pixel,
    input  logic              rst,
    input  logic              line_start_i,
    input  logic              active_i,
    input  logic [7:0]        x_i,
    input  logic [KNOB_W:0]   k_cut_i,
    input  logic [KNOB_W-1:0] q_i,
    input  logic              active_s3_i,
    output logic [7:0]        pix_o
);

    localparam int unsigned YW      = 8 + FRAC_BITS;
    // diff (YW+1 signed) times k_cut (KNOB_W+2 signed)
    localparam int unsigned PW      = YW + KNOB_W + 3;
    // hp (9 signed) times q (KNOB_W+1 signed)
    localparam int unsigned EW      = 9 + KNOB_W + 1;
    // q is scaled so that 512 gives unity emphasis
    localparam int unsigned Q_SHIFT = KNOB_W - 1;

    logic [YW-1:0]      y_q, y_d;
    logic [7:0]         x2_q, x2_d;
    logic [7:0]         ylo3_q, ylo3_d;
    logic signed [10:0] e3_q, e3_d;
    logic [7:0]         pix_q, pix_d;

    logic signed [YW:0]    diff;
    logic signed [PW-1:0]  prod;
    logic [7:0]            ylo;
    logic signed [8:0]     hp;
    logic signed [11:0]    s;

    // Stage 2: IIR state update; reload on line start, hold during blanking.
    always_comb begin
        diff = $signed({1'b0, x_i, {FRAC_BITS{1'b0}}}) - $signed({1'b0, y_q});
        prod = PW'(diff) * PW'($signed({1'b0, k_cut_i}));
        y_d  = y_q;
        if (line_start_i) begin
            y_d = {x_i, {FRAC_BITS{1'b0}}};
        end else if (active_i) begin
            y_d = YW'(PW'($signed({1'b0, y_q})) + (prod >>> KNOB_W));
        end
        x2_d = x_i;
    end

    // Stage 3: high-pass residue scaled by q.
    always_comb begin
        ylo    = y_q[YW-1:FRAC_BITS];
        hp     = $signed({1'b0, x2_q}) - $signed({1'b0, ylo});
        ylo3_d = ylo;
        e3_d   = 11'((EW'(hp) * EW'($signed({1'b0, q_i}))) >>> Q_SHIFT);
    end

    // Stage 4: recombine, clamp to 0..255 and blank outside the visible region.
    always_comb begin
        s = $signed({4'b0000, ylo3_q}) + 12'(e3_q);
        if (s < 12'sd0) begin
            pix_d = 8'd0;
        end else if (s > 12'sd255) begin
            pix_d = 8'd255;
        end else begin
            pix_d = s[7:0];
        end
        if (!active_s3_i) begin
            pix_d = 8'd0;
        end
    end

    // Pipeline registers for stages 2..4.
    always_ff @(posedge clk_pixel) begin
        if (rst) begin
            y_q    <= '0;
            x2_q   <= '0;
            ylo3_q <= '0;
            e3_q   <= '0;
            pix_q  <= '0;
        end else begin
            y_q    <= y_d;
            x2_q   <= x2_d;
            ylo3_q <= ylo3_d;
            e3_q   <= e3_d;
            pix_q  <= pix_d;
        end
    end

    assign pix_o = pix_q;

endmodule

// File: rtl/video_filter.sv
// Filter slot of the video effect chain: control latch, line-start detect,
// sideband delay line and three filter_channel instances.
module video_filter
    import video_pkg::*;
#(
    // Only the default matches the structural depth of filter_channel.
    parameter int unsigned LATENCY   = VIDEO_FILTER_LATENCY,
    parameter int unsigned FRAC_BITS = 10
) (
    input  logic                 clk_pixel,
    input  logic                 rst,
    input  logic [H_COUNT_W-1:0] h_count_in,
    input  logic [V_COUNT_W-1:0] v_count_in,
    input  logic                 active_draw_in,
    input  logic [23:0]          pixel_in,
    input  logic [KNOB_W-1:0]    cutoff,
    input  logic [KNOB_W-1:0]    quality,
    output logic [H_COUNT_W-1:0] h_count_out,
    output logic [V_COUNT_W-1:0] v_count_out,
    output logic                 active_draw_out,
    output logic [23:0]          pixel_out
);

    // k_cut of 1024 makes the IIR transparent
    localparam logic [KNOB_W:0] KCUT_IDENTITY = {1'b1, {KNOB_W{1'b0}}};

    logic                 frame_start;
    logic [KNOB_W:0]      k_cut_q, k_cut_d;
    logic [KNOB_W-1:0]    q_q, q_d;
    logic [KNOB_W-1:0]    q_s2_q, q_s2_d;
    rgb_t                 pix_s1_q, pix_s1_d;
    logic                 ls_s1_q, ls_s1_d;

    logic [H_COUNT_W-1:0] sb_h_q [LATENCY];
    logic [H_COUNT_W-1:0] sb_h_d [LATENCY];
    logic [V_COUNT_W-1:0] sb_v_q [LATENCY];
    logic [V_COUNT_W-1:0] sb_v_d [LATENCY];
    logic                 sb_a_q [LATENCY];
    logic                 sb_a_d [LATENCY];

    logic [7:0]           ch_r, ch_g, ch_b;

    // Cutoff/quality latch on the frame's (0,0) sample; q is re-timed to meet its pixel in stage 3.
    always_comb begin
        frame_start = (h_count_in == '0) && (v_count_in == '0);
        k_cut_d     = k_cut_q;
        q_d         = q_q;
        if (frame_start) begin
            k_cut_d = {1'b0, cutoff} + {{KNOB_W{1'b0}}, 1'b1};
            q_d     = quality;
        end
        q_s2_d = q_q;
    end

    // Stage 1 capture, line-start detect and sideband shift.
    always_comb begin
        pix_s1_d  = pixel_in;
        ls_s1_d   = active_draw_in && (!sb_a_q[0] || (h_count_in == '0));
        sb_h_d[0] = h_count_in;
        sb_v_d[0] = v_count_in;
        sb_a_d[0] = active_draw_in;
        for (int i = 1; i < LATENCY; i++) begin
            sb_h_d[i] = sb_h_q[i-1];
            sb_v_d[i] = sb_v_q[i-1];
            sb_a_d[i] = sb_a_q[i-1];
        end
    end

    // Control, stage 1 and sideband registers.
    always_ff @(posedge clk_pixel) begin
        if (rst) begin
            k_cut_q  <= KCUT_IDENTITY;
            q_q      <= '0;
            q_s2_q   <= '0;
            pix_s1_q <= '0;
            ls_s1_q  <= 1'b0;
            for (int i = 0; i < LATENCY; i++) begin
                sb_h_q[i] <= '0;
                sb_v_q[i] <= '0;
                sb_a_q[i] <= 1'b0;
            end
        end else begin
            k_cut_q  <= k_cut_d;
            q_q      <= q_d;
            q_s2_q   <= q_s2_d;
            pix_s1_q <= pix_s1_d;
            ls_s1_q  <= ls_s1_d;
            for (int i = 0; i < LATENCY; i++) begin
                sb_h_q[i] <= sb_h_d[i];
                sb_v_q[i] <= sb_v_d[i];
                sb_a_q[i] <= sb_a_d[i];
            end
        end
    end

    filter_channel #(.FRAC_BITS(FRAC_BITS)) u_ch_r (
        .clk_pixel    (clk_pixel),
        .rst          (rst),
        .line_start_i (ls_s1_q),
        .active_i     (sb_a_q[0]),
        .x_i          (pix_s1_q.r),
        .k_cut_i      (k_cut_q),
        .q_i          (q_s2_q),
        .active_s3_i  (sb_a_q[2]),
        .pix_o        (ch_r)
    );

    filter_channel #(.FRAC_BITS(FRAC_BITS)) u_ch_g (
        .clk_pixel    (clk_pixel),
        .rst          (rst),
        .line_start_i (ls_s1_q),
        .active_i     (sb_a_q[0]),
        .x_i          (pix_s1_q.g),
        .k_cut_i      (k_cut_q),
        .q_i          (q_s2_q),
        .active_s3_i  (sb_a_q[2]),
        .pix_o        (ch_g)
    );

    filter_channel #(.FRAC_BITS(FRAC_BITS)) u_ch_b (
        .clk_pixel    (clk_pixel),
        .rst          (rst),
        .line_start_i (ls_s1_q),
        .active_i     (sb_a_q[0]),
        .x_i          (pix_s1_q.b),
        .k_cut_i      (k_cut_q),
        .q_i          (q_s2_q),
        .active_s3_i  (sb_a_q[2]),
        .pix_o        (ch_b)
    );

    assign h_count_out     = sb_h_q[LATENCY-1];
    assign v_count_out     = sb_v_q[LATENCY-1];
    assign active_draw_out = sb_a_q[LATENCY-1];
    assign pixel_out       = {ch_r, ch_g, ch_b};

endmodule

// File: tb/tb_video_filter.sv
// Directed bench for video_filter: reset/latency, identity, step low-pass,
// emphasis clamp, line reload and frame-boundary control latch.
module tb_video_filter;

    localparam int MAXN = 300;

    logic        clk_pixel = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] h_count_in = '0;
    logic [9:0]  v_count_in = '0;
    logic        active_draw_in = 1'b0;
    logic [23:0] pixel_in = '0;
    logic [9:0]  cutoff = '0;
    logic [9:0]  quality = '0;
    logic [10:0] h_count_out;
    logic [9:0]  v_count_out;
    logic        active_draw_out;
    logic [23:0] pixel_out;

    int errors = 0;
    int checks = 0;

    logic [10:0] in_h [MAXN];
    logic [9:0]  in_v [MAXN];
    logic        in_a [MAXN];
    logic [23:0] in_p [MAXN];
    logic [9:0]  in_c [MAXN];
    logic [9:0]  in_q [MAXN];
    logic [10:0] got_h [MAXN];
    logic [9:0]  got_v [MAXN];
    logic        got_a [MAXN];
    logic [23:0] got_p [MAXN];
    int          n_in;

    video_filter u_dut (
        .clk_pixel       (clk_pixel),
        .rst             (rst),
        .h_count_in      (h_count_in),
        .v_count_in      (v_count_in),
        .active_draw_in  (active_draw_in),
        .pixel_in        (pixel_in),
        .cutoff          (cutoff),
        .quality         (quality),
        .h_count_out     (h_count_out),
        .v_count_out     (v_count_out),
        .active_draw_out (active_draw_out),
        .pixel_out       (pixel_out)
    );

    always #5 clk_pixel = ~clk_pixel;

    task automatic drive(input logic [10:0] h, input logic [9:0] v, input logic a,
                         input logic [23:0] p);
        h_count_in     = h;
        v_count_in     = v;
        active_draw_in = a;
        pixel_in       = p;
    endtask

    task automatic add(input logic [10:0] h, input logic [9:0] v, input logic a,
                       input logic [23:0] p, input logic [9:0] c, input logic [9:0] q);
        in_h[n_in] = h;
        in_v[n_in] = v;
        in_a[n_in] = a;
        in_p[n_in] = p;
        in_c[n_in] = c;
        in_q[n_in] = q;
        n_in++;
    endtask

    // Feed the queued samples one per cycle, then blanking; got_*[i] is the
    // output seen 4 cycles after sample i was presented.
    task automatic run_seq();
        for (int j = 0; j < n_in + 4; j++) begin
            @(posedge clk_pixel);
            #1;
            if (j < n_in) begin
                drive(in_h[j], in_v[j], in_a[j], in_p[j]);
                cutoff  = in_c[j];
                quality = in_q[j];
            end else begin
                drive(11'd2000, 10'd500, 1'b0, 24'hFFFFFF);
            end
            if (j >= 4) begin
                got_h[j-4] = h_count_out;
                got_v[j-4] = v_count_out;
                got_a[j-4] = active_draw_out;
                got_p[j-4] = pixel_out;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(11'd0, 10'd0, 1'b0, 24'h0);
        repeat (2) @(posedge clk_pixel);
        #1;
        checks++;
        if ({h_count_out, v_count_out, active_draw_out, pixel_out} !== '0) begin
            $display("FAIL reset_state: got h=%0d v=%0d a=%b p=%h, want all 0",
                     h_count_out, v_count_out, active_draw_out, pixel_out);
            errors++;
        end
        rst = 1'b0;
        drive(11'd10, 10'd5, 1'b1, 24'h112233);
        for (int j = 1; j < 6; j++) begin
            @(posedge clk_pixel);
            #1;
            drive(11'(10 + j), 10'd5, 1'b1, 24'h112233 + 24'(j));
        end
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk_pixel);
            #1;
            checks++;
            if ({h_count_out, v_count_out, active_draw_out, pixel_out} !== '0) begin
                $display("FAIL reset_hold[%0d]: got h=%0d v=%0d a=%b p=%h, want all 0", k,
                         h_count_out, v_count_out, active_draw_out, pixel_out);
                errors++;
            end
            drive(11'(16 + k), 10'd5, 1'b1, 24'h445566);
        end
        rst = 1'b0;
        drive(11'd20, 10'd7, 1'b1, 24'hA0B0C0);
        for (int m = 1; m <= 4; m++) begin
            @(posedge clk_pixel);
            #1;
            checks++;
            if (m < 4) begin
                if ({h_count_out, v_count_out, active_draw_out, pixel_out} !== '0) begin
                    $display("FAIL reset_flush[%0d]: got h=%0d a=%b p=%h, want all 0", m,
                             h_count_out, active_draw_out, pixel_out);
                    errors++;
                end
            end else begin
                if (h_count_out !== 11'd20 || v_count_out !== 10'd7 ||
                    active_draw_out !== 1'b1 || pixel_out !== 24'hA0B0C0) begin
                    $display("FAIL reset_first_out: got h=%0d v=%0d a=%b p=%h, want 20 7 1 a0b0c0",
                             h_count_out, v_count_out, active_draw_out, pixel_out);
                    errors++;
                end
            end
            drive(11'(20 + m), 10'd7, 1'b1, 24'h010203);
        end
        // Flush with blanking before the next scenario.
        for (int j = 0; j < 4; j++) begin
            @(posedge clk_pixel);
            #1;
            drive(11'd2000, 10'd500, 1'b0, 24'h0);
        end
    endtask

    task automatic test_identity();
        n_in = 0;
        for (int i = 0; i < 256; i++) begin
            add(11'(i), 10'd0, 1'b1, {8'(i), ~8'(i), 8'(i) ^ 8'h5A}, 10'd1023, 10'd512);
        end
        run_seq();
        for (int i = 0; i < 256; i++) begin
            checks++;
            if (got_p[i] !== in_p[i] || got_h[i] !== in_h[i] || got_v[i] !== in_v[i] ||
                got_a[i] !== 1'b1) begin
                $display("FAIL identity[%0d]: got h=%0d v=%0d a=%b p=%h, want h=%0d v=0 a=1 p=%h",
                         i, got_h[i], got_v[i], got_a[i], got_p[i], in_h[i], in_p[i]);
                errors++;
            end
        end
    endtask

    task automatic test_step_lowpass();
        logic [7:0] exp_r [4];
        exp_r = '{8'd0, 8'd127, 8'd191, 8'd223};
        n_in = 0;
        add(11'd0, 10'd0, 1'b1, 24'h000000, 10'd511, 10'd0);
        for (int i = 1; i < 4; i++) add(11'(i), 10'd0, 1'b1, 24'hFF0000, 10'd511, 10'd0);
        run_seq();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_p[i] !== {exp_r[i], 16'h0000}) begin
                $display("FAIL step_lowpass[%0d]: got %h, want %h", i, got_p[i],
                         {exp_r[i], 16'h0000});
                errors++;
            end
        end
    endtask

    task automatic test_emphasis_clamp();
        logic [7:0] exp_r [4];
        exp_r = '{8'd0, 8'd255, 8'd255, 8'd255};
        n_in = 0;
        add(11'd0, 10'd0, 1'b1, 24'h000000, 10'd511, 10'd1023);
        for (int i = 1; i < 4; i++) add(11'(i), 10'd0, 1'b1, 24'hFF0000, 10'd511, 10'd1023);
        run_seq();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_p[i] !== {exp_r[i], 16'h0000}) begin
                $display("FAIL emph_rise[%0d]: got %h, want %h", i, got_p[i],
                         {exp_r[i], 16'h0000});
                errors++;
            end
        end
        exp_r = '{8'd255, 8'd0, 8'd0, 8'd0};
        n_in = 0;
        add(11'd0, 10'd0, 1'b1, 24'hFF0000, 10'd511, 10'd1023);
        add(11'd1, 10'd0, 1'b1, 24'h000000, 10'd511, 10'd1023);
        add(11'd2, 10'd0, 1'b1, 24'h000000, 10'd511, 10'd1023);
        run_seq();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (got_p[i] !== {exp_r[i], 16'h0000}) begin
                $display("FAIL emph_fall[%0d]: got %h, want %h", i, got_p[i],
                         {exp_r[i], 16'h0000});
                errors++;
            end
        end
    endtask

    task automatic test_line_reload();
        logic [7:0] exp_r [7];
        logic       exp_a [7];
        exp_r = '{8'd50, 8'd59, 8'd68, 8'd0, 8'd10, 8'd10, 8'd250};
        exp_a = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        n_in = 0;
        add(11'd0, 10'd0, 1'b1, 24'h320000, 10'd63, 10'd0);
        add(11'd1, 10'd0, 1'b1, 24'hC80000, 10'd63, 10'd0);
        add(11'd2, 10'd0, 1'b1, 24'hC80000, 10'd63, 10'd0);
        add(11'd3, 10'd0, 1'b0, 24'h4D4D4D, 10'd63, 10'd0);
        add(11'd0, 10'd1, 1'b1, 24'h0A0000, 10'd63, 10'd0);
        add(11'd1, 10'd1, 1'b1, 24'h0A0000, 10'd63, 10'd0);
        add(11'd0, 10'd2, 1'b1, 24'hFA0000, 10'd63, 10'd0);
        run_seq();
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (got_p[i] !== {exp_r[i], 16'h0000} || got_a[i] !== exp_a[i]) begin
                $display("FAIL line_reload[%0d]: got a=%b p=%h, want a=%b p=%h", i, got_a[i],
                         got_p[i], exp_a[i], {exp_r[i], 16'h0000});
                errors++;
            end
        end
    endtask

    task automatic test_ctrl_latch();
        logic [7:0] exp_r [7];
        exp_r = '{8'd100, 8'd200, 8'd50, 8'd0, 8'd100, 8'd100, 8'd99};
        n_in = 0;
        add(11'd0, 10'd0, 1'b1, 24'h640000, 10'd1023, 10'd0);
        add(11'd1, 10'd0, 1'b1, 24'hC80000, 10'd0, 10'd0);
        add(11'd2, 10'd0, 1'b1, 24'h320000, 10'd0, 10'd0);
        add(11'd3, 10'd0, 1'b0, 24'h4D0000, 10'd0, 10'd0);
        add(11'd0, 10'd0, 1'b1, 24'h640000, 10'd0, 10'd0);
        add(11'd1, 10'd0, 1'b1, 24'hC80000, 10'd0, 10'd0);
        add(11'd2, 10'd0, 1'b1, 24'h000000, 10'd0, 10'd0);
        run_seq();
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (got_p[i] !== {exp_r[i], 16'h0000}) begin
                $display("FAIL ctrl_latch[%0d]: got %h, want %h", i, got_p[i],
                         {exp_r[i], 16'h0000});
                errors++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_step_lowpass();
        test_emphasis_clamp();
        test_line_reload();
        test_ctrl_latch();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
